// File: rtl/pipe_controller.sv
// pipe_controller: MIPS 5-stage control decode with E/M/W control pipeline registers
module pipe_controller #(
  parameter bit ILLEGAL_BUBBLE = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op_d,
  input  logic [5:0] funct_d,
  input  logic       equal_d,
  input  logic       flush_e,
  input  logic       stall_e,
  output logic       pcsrc_d,
  output logic       jump_d,
  output logic       illegal_d,
  output logic       regwrite_e,
  output logic       memtoreg_e,
  output logic       memwrite_e,
  output logic       alusrc_e,
  output logic       regdst_e,
  output logic [2:0] alucontrol_e,
  output logic       regwrite_m,
  output logic       memtoreg_m,
  output logic       memwrite_m,
  output logic       regwrite_w,
  output logic       memtoreg_w
);
  // raw = {regwrite, memtoreg, memwrite, alusrc, regdst, branch, jump, aluop[1:0]}
  logic [8:0] raw;
  logic       op_ok, funct_ok;
  logic [2:0] alu_r, alu_d;
  logic [7:0] ctrl_d, ctrl_e;
  logic [2:0] ctrl_m;
  logic [1:0] ctrl_w;
  always_comb begin
    raw = '0;
    op_ok = 1'b1;
    case (op_d)
      6'b000000: raw = 9'b10001_00_10;
      6'b100011: raw = 9'b11010_00_00;
      6'b101011: raw = 9'b00110_00_00;
      6'b000100: raw = 9'b00000_10_01;
      6'b001000: raw = 9'b10010_00_00;
      6'b000010: raw = 9'b00000_01_00;
      default:   op_ok = 1'b0;
    endcase
  end
  always_comb begin
    alu_r = 3'b010;
    funct_ok = 1'b1;
    case (funct_d)
      6'b100000: alu_r = 3'b010;
      6'b100010: alu_r = 3'b110;
      6'b100100: alu_r = 3'b000;
      6'b100101: alu_r = 3'b001;
      6'b101010: alu_r = 3'b111;
      default:   funct_ok = 1'b0;
    endcase
  end
  assign alu_d     = raw[1:0] == 2'b10 ? alu_r : raw[0] ? 3'b110 : 3'b010;
  assign illegal_d = !op_ok || (raw[1:0] == 2'b10 && !funct_ok);
  assign ctrl_d    = illegal_d ? (ILLEGAL_BUBBLE ? 8'b0 : 8'b00000_010) : {raw[8:4], alu_d};
  assign pcsrc_d   = !illegal_d && raw[3] && equal_d;
  assign jump_d    = !illegal_d && raw[2];
  // a stalled E must not also advance into M, so M takes a bubble instead
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_e <= '0;
      ctrl_m <= '0;
      ctrl_w <= '0;
    end else begin
      ctrl_e <= flush_e ? '0 : stall_e ? ctrl_e : ctrl_d;
      ctrl_m <= (stall_e && !flush_e) ? '0 : ctrl_e[7:5];
      ctrl_w <= ctrl_m[2:1];
    end
  end
  assign {regwrite_e, memtoreg_e, memwrite_e, alusrc_e, regdst_e, alucontrol_e} = ctrl_e;
  assign {regwrite_m, memtoreg_m, memwrite_m} = ctrl_m;
  assign {regwrite_w, memtoreg_w} = ctrl_w;
endmodule

// File: tb/tb_pipe_controller.sv
// tb_pipe_controller: scoreboard bench for both illegal-handling variants of pipe_controller
module tb_pipe_controller;
  localparam logic [7:0] ADD = 8'b10001_010, SUB = 8'b10001_110, AND_ = 8'b10001_000;
  localparam logic [7:0] OR_ = 8'b10001_001, SLT = 8'b10001_111, LW = 8'b11010_010;
  localparam logic [7:0] SW = 8'b00110_010, BEQ = 8'b00000_110, ADDI = 8'b10010_010;
  localparam logic [7:0] J = 8'b00000_010, ILB = 8'b0, ILA = 8'b00000_010;
  logic clk = 0, reset = 1;
  logic [5:0] op_d = 6'b100011, funct_d = 6'b101010;
  logic equal_d = 1, flush_e = 0, stall_e = 1;
  logic b_pc, b_j, b_il, b_rwe, b_mte, b_mwe, b_ase, b_rde, b_rwm, b_mtm, b_mwm, b_rww, b_mtw;
  logic a_pc, a_j, a_il, a_rwe, a_mte, a_mwe, a_ase, a_rde, a_rwm, a_mtm, a_mwm, a_rww, a_mtw;
  logic [2:0] b_alu, a_alu;
  int errors = 0, checks = 0;
  typedef struct {
    logic [2:0] c;
    logic [7:0] be, ae;
    logic [2:0] bm, am;
    logic [1:0] bw, aw;
  } rec_t;
  rec_t q[$];
  logic [7:0] mbe = 0, mae = 0, mbm = 0, mam = 0, mbw = 0, maw = 0;
  pipe_controller #(.ILLEGAL_BUBBLE(1'b1)) dut_b (
    .clk(clk), .reset(reset), .op_d(op_d), .funct_d(funct_d), .equal_d(equal_d),
    .flush_e(flush_e), .stall_e(stall_e), .pcsrc_d(b_pc), .jump_d(b_j), .illegal_d(b_il),
    .regwrite_e(b_rwe), .memtoreg_e(b_mte), .memwrite_e(b_mwe), .alusrc_e(b_ase),
    .regdst_e(b_rde), .alucontrol_e(b_alu), .regwrite_m(b_rwm), .memtoreg_m(b_mtm),
    .memwrite_m(b_mwm), .regwrite_w(b_rww), .memtoreg_w(b_mtw));
  pipe_controller #(.ILLEGAL_BUBBLE(1'b0)) dut_a (
    .clk(clk), .reset(reset), .op_d(op_d), .funct_d(funct_d), .equal_d(equal_d),
    .flush_e(flush_e), .stall_e(stall_e), .pcsrc_d(a_pc), .jump_d(a_j), .illegal_d(a_il),
    .regwrite_e(a_rwe), .memtoreg_e(a_mte), .memwrite_e(a_mwe), .alusrc_e(a_ase),
    .regdst_e(a_rde), .alucontrol_e(a_alu), .regwrite_m(a_rwm), .memtoreg_m(a_mtm),
    .memwrite_m(a_mwm), .regwrite_w(a_rww), .memtoreg_w(a_mtw));
  logic [7:0] b_e, a_e;
  logic [2:0] b_m, a_m, b_c, a_c;
  logic [1:0] b_w, a_w;
  assign b_e = {b_rwe, b_mte, b_mwe, b_ase, b_rde, b_alu};
  assign a_e = {a_rwe, a_mte, a_mwe, a_ase, a_rde, a_alu};
  assign b_m = {b_rwm, b_mtm, b_mwm};
  assign a_m = {a_rwm, a_mtm, a_mwm};
  assign b_w = {b_rww, b_mtw};
  assign a_w = {a_rww, a_mtw};
  assign b_c = {b_pc, b_j, b_il};
  assign a_c = {a_pc, a_j, a_il};
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", n, act, exp, $time);
    end
  endtask
  task automatic rst_chk(input string n);
    chk({n, " e_b"}, b_e, 8'd0);
    chk({n, " e_a"}, a_e, 8'd0);
    chk({n, " m_b"}, {5'd0, b_m}, 8'd0);
    chk({n, " m_a"}, {5'd0, a_m}, 8'd0);
    chk({n, " w_b"}, {6'd0, b_w}, 8'd0);
    chk({n, " w_a"}, {6'd0, a_w}, 8'd0);
  endtask
  always @(negedge clk) begin : monitor
    rec_t r;
    if (q.size() != 0) begin
      r = q.pop_front();
      chk("comb_b", {5'd0, b_c}, {5'd0, r.c});
      chk("comb_a", {5'd0, a_c}, {5'd0, r.c});
      chk("e_b", b_e, r.be);
      chk("e_a", a_e, r.ae);
      chk("m_b", {5'd0, b_m}, {5'd0, r.bm});
      chk("m_a", {5'd0, a_m}, {5'd0, r.am});
      chk("w_b", {6'd0, b_w}, {6'd0, r.bw});
      chk("w_a", {6'd0, a_w}, {6'd0, r.aw});
    end
  end
  task automatic step(input logic [5:0] op, input logic [5:0] fn, input logic eq,
                      input logic fl, input logic st, input logic [7:0] xb,
                      input logic [7:0] xa, input logic [2:0] xc);
    rec_t r;
    op_d = op; funct_d = fn; equal_d = eq; flush_e = fl; stall_e = st;
    mbw = mbm; mbm = (st && !fl) ? 8'd0 : mbe; mbe = fl ? 8'd0 : st ? mbe : xb;
    maw = mam; mam = (st && !fl) ? 8'd0 : mae; mae = fl ? 8'd0 : st ? mae : xa;
    r.c = xc; r.be = mbe; r.ae = mae;
    r.bm = mbm[7:5]; r.am = mam[7:5]; r.bw = mbw[7:6]; r.aw = maw[7:6];
    q.push_back(r);
    @(negedge clk); #1;
  endtask
  task automatic r_(input logic [5:0] fn, input logic [7:0] x);
    step(6'b000000, fn, 1'b0, 1'b0, 1'b0, x, x, 3'b000);
  endtask
  task automatic i_(input logic [5:0] op, input logic [7:0] x);
    step(op, 6'b000000, 1'b0, 1'b0, 1'b0, x, x, 3'b000);
  endtask
  task automatic model_clear();
    mbe = 0; mae = 0; mbm = 0; mam = 0; mbw = 0; maw = 0;
  endtask
  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    #2 reset = 0;
    #1 rst_chk("reset_async");
    @(negedge clk); #1;
    rst_chk("reset_held");
    reset = 1; stall_e = 0; equal_d = 0;
    r_(6'b100010, SUB);
    r_(6'b100000, ADD);
    r_(6'b100000, ADD);
    r_(6'b100000, ADD);
    i_(6'b100011, LW);
    i_(6'b101011, SW);
    i_(6'b001000, ADDI);
    r_(6'b100100, AND_);
    r_(6'b100101, OR_);
    r_(6'b101010, SLT);
    step(6'b000100, 6'b000000, 1'b1, 1'b0, 1'b0, BEQ, BEQ, 3'b100);
    step(6'b000100, 6'b000000, 1'b0, 1'b0, 1'b0, BEQ, BEQ, 3'b000);
    step(6'b000010, 6'b000000, 1'b0, 1'b0, 1'b0, J, J, 3'b010);
    i_(6'b100011, LW);
    step(6'b001000, 6'b000000, 1'b0, 1'b0, 1'b1, ADDI, ADDI, 3'b000);
    step(6'b001000, 6'b000000, 1'b0, 1'b0, 1'b1, ADDI, ADDI, 3'b000);
    i_(6'b001000, ADDI);
    r_(6'b100000, ADD);
    step(6'b101011, 6'b000000, 1'b0, 1'b1, 1'b1, SW, SW, 3'b000);
    r_(6'b100010, SUB);
    step(6'b101011, 6'b000000, 1'b0, 1'b1, 1'b0, SW, SW, 3'b000);
    r_(6'b100000, ADD);
    step(6'b111111, 6'b100000, 1'b1, 1'b0, 1'b0, ILB, ILA, 3'b001);
    step(6'b000000, 6'b000000, 1'b1, 1'b0, 1'b0, ILB, ILA, 3'b001);
    i_(6'b101011, SW);
    i_(6'b101011, SW);
    i_(6'b101011, SW);
    i_(6'b100011, LW);
    i_(6'b001000, ADDI);
    reset = 0;
    #1 rst_chk("reset_mid");
    model_clear();
    #1 reset = 1;
    r_(6'b101010, SLT);
    i_(6'b100011, LW);
    i_(6'b101011, SW);
    r_(6'b100000, ADD);
    for (int i = 0; i < 5 && q.size() != 0; i++) @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pipe_controller.md
Name: pipe_controller

Overview:
- Pipelined control unit for the 5-stage MIPS core.
- Decodes op/funct in Decode (D) into main-decoder and ALU-decoder controls. Produces the 3-bit ALU function code consumed by the execute-stage ALU.
- Carries write-back and memory controls through the Execute (E), Memory (M) and Writeback (W) pipeline registers.
- Provides the hazard-unit hooks: flush and stall of E.

Parameters:
- ILLEGAL_BUBBLE, 1: when 1, an illegal opcode/funct decodes to all-zero controls. When 0, it decodes as ADD with regwrite 0.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- op_d  in  6  instruction[31:26] in D
- funct_d  in  6  instruction[5:0] in D
- equal_d  in  1  register-compare result in D
- flush_e  in  1  synchronous clear of the E control register (bubble)
- stall_e  in  1  hold the E control register
- pcsrc_d  out  1  branch taken: branch_d & equal_d (combinational)
- jump_d  out  1  j instruction (combinational)
- illegal_d  out  1  unsupported op/funct (combinational)
- regwrite_e, memtoreg_e, memwrite_e, alusrc_e, regdst_e  out  1 each  E-stage controls
- alucontrol_e  out  3  ALU function code in E
- regwrite_m, memtoreg_m, memwrite_m  out  1 each  M-stage controls
- regwrite_w, memtoreg_w  out  1 each  W-stage controls

Behaviour:

Main decode (combinational, D):
- R-type 000000: regwrite 1, regdst 1, aluop 10
- lw 100011: regwrite 1, alusrc 1, memtoreg 1, aluop 00
- sw 101011: alusrc 1, memwrite 1, aluop 00
- beq 000100: branch 1, aluop 01
- addi 001000: regwrite 1, alusrc 1, aluop 00
- j 000010: jump 1, all other controls 0
- Any other op: illegal_d=1.

ALU decode:
- aluop 00 → 010 (ADD); aluop 01 → 110 (SUB).
- aluop 10 uses funct: 100000→010 ADD, 100010→110 SUB, 100100→000 AND, 100101→001 OR, 101010→111 SLT.
- Other funct under R-type: illegal_d=1.
- Codes 011, 100 and 101 are never generated.

Illegal handling:
- ILLEGAL_BUBBLE=1: all D controls forced 0, alucontrol 000.
- ILLEGAL_BUBBLE=0: alucontrol 010, all write enables 0.
- pcsrc_d and jump_d are always 0 when illegal.

Pipeline registers (all updated on rising clk):
- D→E: loads the decoded controls unless stall_e=1 (hold) or flush_e=1 (clear to 0, alucontrol 000).
- flush_e has priority over stall_e.
- E→M: loads E controls. When stall_e=1 and flush_e=0, M loads zeros (a bubble), so a stalled instruction never duplicates into M.
- M→W: always loads M controls.
- Latency: a decoded control appears at E one cycle after D, at M after two cycles, at W after three.

Reset:
- reset low asynchronously clears every registered output to 0 (alucontrol_e=000), independent of clk.
- Reset mid-instruction discards all in-flight controls. The first post-reset edge loads only D.
- Combinational outputs follow their inputs during reset.

Simultaneous events:
- flush_e and stall_e both high: E cleared, M receives the previous E.
- beq in D with equal_d=0: pcsrc_d=0; E still carries alucontrol 110 and no write enables.
- No internal state other than the three pipeline registers; no FSM beyond the shift structure.

Test Plan:
1. Reset low with arbitrary inputs → all E/M/W outputs 0 immediately. Release, drive op_d=000000, funct_d=100010 → next edge regwrite_e=1, regdst_e=1, alucontrol_e=110. Two edges later regwrite_w=1.
2. Sequence lw, sw, addi, R-AND, R-OR, R-SLT, one per cycle:
   - alucontrol_e = 010, 010, 010, 000, 001, 111
   - memtoreg_w=1 three cycles after lw
   - memwrite_m=1 two cycles after sw
3. op_d=000100: equal_d=1 → pcsrc_d=1; equal_d=0 → pcsrc_d=0. In both cases alucontrol_e=110 and regwrite_e=0. op_d=000010 → jump_d=1.
4. lw in D with stall_e=1 for 2 cycles → E holds the lw controls and M shows zeros for 2 cycles. On release, memtoreg_m=1 exactly once.
5. flush_e=1 together with stall_e=1 → E all zero, alucontrol_e=000, and M takes the prior E contents.
6. op_d=111111, then R-type funct 000000:
   - illegal_d=1 both times, with no write enables propagating to W.
   - Repeat with ILLEGAL_BUBBLE=0 → alucontrol_e=010, regwrite_e=0.
   - Assert reset mid-sequence → outputs cleared asynchronously before the next edge.
